branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
- Sits between fetch/execute and the 2-bit saturating-counter `predictor`.
- On the fetch side, it issues a `request` to `predictor` and captures the returned `prediction`. It holds each in-flight branch's predicted direction in an in-order FIFO.
- On the execute side, it retires each resolved branch against the FIFO head and drives the predictor update (`result`/`taken`). It also raises a mispredict flush and keeps statistics counters.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of two, ≥2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- br_valid  in  1  fetch presents a branch.
- br_ready  out  1  block can accept a branch this cycle.
- pred_valid  out  1  one-cycle pulse; `pred_taken` is valid.
- pred_taken  out  1  predicted direction for the branch accepted the previous cycle.
- ex_valid  in  1  execute presents the oldest branch outcome.
- ex_taken  in  1  actual direction.
- ex_ready  out  1  outcome consumed this cycle.
- request  out  1  to predictor; combinational = `br_valid & br_ready`.
- prediction  in  1  from predictor; valid the cycle after `request`.
- result  out  1  to predictor; combinational = `ex_valid & ex_ready`.
- taken  out  1  to predictor; = `ex_taken` when `result`=1, else 0.
- mispredict  out  1  registered one-cycle flush pulse.
- branch_count  out  CNT_W  resolved branches, saturating.
- miss_count  out  CNT_W  mispredicted branches, saturating.

Behaviour:
- Reset: `rst_n`=0 at a posedge clears the following, regardless of other inputs:
  - FIFO pointers/occupancy and the capture-pending flag;
  - `pred_valid`, `pred_taken`, `mispredict`;
  - both counters.
- `request` and `result` are never high in the same cycle, because the predictor ignores updates on request cycles.

Capture:
- Branch accept (`br_valid & br_ready`) sets `cap_pend` for exactly the next cycle.
- In that cycle:
  - `pred_valid`=1 and `pred_taken`=`prediction` (combinational from `prediction`, gated by `cap_pend`);
  - `prediction` is written to the FIFO tail, occupancy +1.
- Fetch latency is 1 cycle from accept to `pred_valid`. Maximum accept rate is one branch every 2 cycles.

br_ready:
- Equals `!cap_pend & (occupancy + cap_pend < DEPTH) & !(ex_valid & ex_ready) & !mispredict`.
- Resolve has priority over fetch.

ex_ready:
- Equals `ex_valid & (occupancy > 0)`.
- The entry being captured in the current cycle is not resolvable until the following cycle.
- With an empty FIFO (including capture-pending only), `ex_ready`=0.

Resolve:
- On `ex_valid & ex_ready`:
  - pop the head;
  - `result`=1 and `taken`=`ex_taken`;
  - `branch_count` +1, saturating at all-ones.
- If head ≠ `ex_taken`:
  - `miss_count` +1, saturating;
  - `mispredict`=1 on the next cycle;
  - all remaining FIFO entries are discarded at the same edge (occupancy → 0).
- Mispredict coinciding with `cap_pend`:
  - the captured prediction belongs to a younger, squashed branch;
  - it is not written, and `pred_valid` is forced 0.
- Resolve and capture in the same cycle without mispredict: pop and push both occur; occupancy unchanged.

Other rules:
- Pointers wrap modulo DEPTH. Occupancy is held in log2(DEPTH)+1 bits.
- The FIFO is full at occupancy = DEPTH. Accept is also blocked when occupancy = DEPTH−1 and `cap_pend`=1.
- `br_ready` is 0 during the `mispredict` cycle. Fetch redirect is owned by the consumer.
- No outputs are X after reset. Counters never wrap.

Test Plan:
- Reset, then a single branch with predictor at reset state (strongly taken): accept at cycle 1 → `request`=1 at cycle 1; `pred_valid`=1 and `pred_taken`=1 at cycle 2. Then `ex_valid`=1, `ex_taken`=1 → `result`=1, `taken`=1, `mispredict` stays 0, `branch_count`=1, `miss_count`=0.
- Mispredict flush: three branches in flight, all predicted 1. Resolve the oldest with `ex_taken`=0 → `mispredict` pulses 1 for one cycle, occupancy goes 3→0, `miss_count`=1. A following `ex_valid` gets `ex_ready`=0.
- Full FIFO, DEPTH=4: accept every other cycle until occupancy=4 → `br_ready` stays 0 with `br_valid` held. One resolve → `br_ready`=1 the cycle after.
- Arbitration: `br_valid`=1 and `ex_valid`=1 in the same cycle with a non-empty FIFO → `result`=1, `request`=0, `br_ready`=0; the branch is accepted next cycle.
- Squash race: accept a branch in cycle N, and in cycle N+1 resolve the older head as mispredicted → `pred_valid`=0 in N+1, occupancy=0 after the edge, `mispredict`=1 in N+2.
- Reset mid-operation: two entries, `cap_pend`=1, `rst_n`=0 for one cycle → occupancy=0, `pred_valid`=0, `mispredict`=0, counters=0. Saturation check: preload toward `branch_count`=16'hFFFF; one more resolve leaves it at 16'hFFFF.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// In-order branch prediction tracker between fetch/execute and a 2-bit predictor.
// Captures predictions into a FIFO, resolves them in order, flushes on mispredict.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_taken,
  output logic             ex_ready,
  output logic             request,
  input  logic             prediction,
  output logic             result,
  output logic             taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int EW = AW + 2;
  localparam logic [EW-1:0] DEPTH_L = DEPTH[EW-1:0];

  logic [DEPTH-1:0] pred_mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic [EW-1:0]    occ_ext;
  logic             cap_pend;
  logic             head;
  logic             res;
  logic             miss;
  logic             push;

  // Handshakes: a transfer happens in any cycle where valid and ready are both
  // high; ready may depend on valid combinationally, valid never waits on ready.
  // Resolve wins over fetch, so a resolve cycle never issues a predictor request.
  always_comb begin
    ex_ready   = ex_valid & (occ != '0);
    res        = ex_valid & ex_ready;
    head       = pred_mem[rd_ptr];
    miss       = res & (head != ex_taken);
    occ_ext    = {1'b0, occ} + {{OW{1'b0}}, cap_pend};
    br_ready   = !cap_pend & (occ_ext < DEPTH_L) & !res & !mispredict;
    request    = br_valid & br_ready;
    result     = res;
    taken      = res & ex_taken;
    // A capture racing a mispredict belongs to a squashed younger branch.
    pred_valid = cap_pend & !miss;
    pred_taken = pred_valid & prediction;
    push       = pred_valid;
  end

  always_ff @(posedge clk) begin
    if (push) pred_mem[wr_ptr] <= prediction;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      cap_pend     <= 1'b0;
      mispredict   <= 1'b0;
      branch_count <= '0;
      miss_count   <= '0;
    end else begin
      cap_pend   <= request;
      mispredict <= miss;
      if (miss) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (res)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, res})
          2'b10:   occ <= occ + OW'(1);
          2'b01:   occ <= occ - OW'(1);
          default: occ <= occ;
        endcase
      end
      if (res && (branch_count != '1)) branch_count <= branch_count + CNT_W'(1);
      if (miss && (miss_count != '1))  miss_count   <= miss_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: queue-based reference model, predictor stub,
// directed scenarios followed by randomized traffic.
module tb_branch_resolve_queue;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             br_valid = 1'b0;
  logic             ex_valid = 1'b0;
  logic             ex_taken = 1'b0;
  logic             prediction;
  logic             br_ready, pred_valid, pred_taken, ex_ready;
  logic             request, result, taken, mispredict;
  logic [CNT_W-1:0] branch_count, miss_count;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .br_valid(br_valid), .br_ready(br_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_ready(ex_ready),
    .request(request), .prediction(prediction),
    .result(result), .taken(taken), .mispredict(mispredict),
    .branch_count(branch_count), .miss_count(miss_count)
  );

  // Predictor stub: 2-bit saturating counter, reset to strongly taken.
  logic [1:0] stub_ctr;
  logic       stub_pred;
  assign prediction = stub_pred;
  always @(posedge clk) begin
    if (!rst_n) begin
      stub_ctr  <= 2'd3;
      stub_pred <= 1'b0;
    end else begin
      if (request) stub_pred <= stub_ctr[1];
      if (result) begin
        if (taken && stub_ctr != 2'd3)       stub_ctr <= stub_ctr + 2'd1;
        else if (!taken && stub_ctr != 2'd0) stub_ctr <= stub_ctr - 2'd1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: one entry per in-flight branch, oldest first.
  bit         m_q[$];
  bit         m_cap = 0;
  bit         m_pend = 0;
  bit         m_mis = 0;
  bit         m_live = 0;
  int         m_bc = 0;
  int         m_mc = 0;
  int         m_ctr = 3;
  logic [0:0] exp_pred_q[$];
  logic [0:0] exp_res_q[$];

  always @(negedge clk) begin : model
    int occ;
    bit res, miss, e_brr, e_req, e_pv;
    occ   = m_q.size();
    res   = ex_valid && (occ > 0);
    miss  = 0;
    if (res) miss = (m_q[0] != ex_taken);
    e_brr = !m_cap && (occ + int'(m_cap) < DEPTH) && !res && !m_mis;
    e_req = br_valid && e_brr;
    e_pv  = m_cap && !miss;
    if (m_live) begin
      chk("br_ready", br_ready, e_brr);
      chk("ex_ready", ex_ready, res);
      chk("request", request, e_req);
      chk("result", result, res);
      chk("pred_valid", pred_valid, e_pv);
      chk("mispredict", mispredict, m_mis);
      chk("branch_count", branch_count, m_bc);
      chk("miss_count", miss_count, m_mc);
      if (e_pv) exp_pred_q.push_back(m_pend);
      if (res)  exp_res_q.push_back(ex_taken);
    end
    if (res) begin
      if (miss) m_q.delete();
      else void'(m_q.pop_front());
      if (m_bc < CNT_MAX) m_bc++;
      if (miss && m_mc < CNT_MAX) m_mc++;
      if (ex_taken) m_ctr = (m_ctr < 3) ? m_ctr + 1 : 3;
      else          m_ctr = (m_ctr > 0) ? m_ctr - 1 : 0;
    end
    if (e_pv) m_q.push_back(m_pend);
    m_mis = miss;
    m_cap = e_req;
    if (e_req) m_pend = (m_ctr >= 2);
    if (!rst_n) begin
      m_q.delete();
      m_cap  = 0;
      m_pend = 0;
      m_mis  = 0;
      m_bc   = 0;
      m_mc   = 0;
      m_ctr  = 3;
      m_live = 1;
    end
  end

  always @(negedge clk) begin : monitor
    #1;
    if (m_live) begin
      if (pred_valid) begin
        if (exp_pred_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pred_unexpected: got 1 expected 0 at %0t", $time);
        end else chk("pred_taken", pred_taken, exp_pred_q.pop_front());
      end
      if (result) begin
        if (exp_res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_unexpected: got 1 expected 0 at %0t", $time);
        end else chk("taken", taken, exp_res_q.pop_front());
      end else chk("taken_idle", taken, 0);
    end
  end

  task automatic cyc(input bit bv, input bit ev, input bit et);
    @(posedge clk); #1;
    rst_n = 1'b1; br_valid = bv; ex_valid = ev; ex_taken = et;
  endtask

  task automatic rst_cyc();
    @(posedge clk); #1;
    rst_n = 1'b0; br_valid = 1'b0; ex_valid = 1'b0; ex_taken = 1'b0;
  endtask

  function automatic bit head_or_rand();
    if (m_q.size() > 0) return m_q[0];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drain();
    for (int i = 0; i < 50 && (m_q.size() > 0 || m_cap); i++)
      cyc(0, 1, 1'($urandom_range(0, 1)));
    chk("drain_timeout", m_q.size() + int'(m_cap), 0);
    cyc(0, 0, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (2) @(posedge clk);
    // single correctly predicted branch
    cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 1, 1); cyc(0, 0, 0);
    // three in flight, oldest mispredicted, then a resolve against empty FIFO
    repeat (6) cyc(1, 0, 0);
    cyc(0, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 1, 1); cyc(0, 0, 0);
    // fill to DEPTH with fetch held, one resolve while fetch keeps asking
    repeat (10) cyc(1, 0, 0);
    cyc(1, 1, head_or_rand());
    repeat (3) cyc(1, 0, 0);
    drain();
    // squash race: mispredict resolves while a younger capture is pending
    cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
    cyc(0, 1, !head_or_rand());
    cyc(0, 0, 0); cyc(0, 0, 0);
    // reset with two entries and a pending capture
    repeat (5) cyc(1, 0, 0);
    rst_cyc();
    cyc(0, 1, 1); cyc(0, 0, 0);
    // drive both counters into saturation
    repeat (CNT_MAX + 15) begin
      cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 1, !head_or_rand()); cyc(0, 0, 0);
    end
    repeat (3) begin
      cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 1, head_or_rand());
    end
    // randomized traffic
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0) rst_cyc();
      else cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 9) < 7) ? head_or_rand() : 1'($urandom_range(0, 1)));
    end
    drain();
    cyc(0, 0, 0); cyc(0, 0, 0);
    @(posedge clk); #2;
    chk("pred_q_empty", exp_pred_q.size(), 0);
    chk("res_q_empty", exp_res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
